// File: rtl/spi_arb_pkg.sv
// Shared constants for the SPI transaction arbiter: FSM state encoding and byte widths.
package spi_arb_pkg;

    localparam int BYTE_W  = 8;
    localparam int STATE_W = 3;

    localparam logic [BYTE_W-1:0] TIMEOUT_BYTE = 8'hFF;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_GRANT   = 3'd1;
    localparam logic [STATE_W-1:0] ST_LAUNCH  = 3'd2;
    localparam logic [STATE_W-1:0] ST_WAIT_RX = 3'd3;
    localparam logic [STATE_W-1:0] ST_RESP    = 3'd4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: index of the first requester at or after i_ptr, wrapping.
// The pointer register itself lives in the caller.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_any
);

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;

    // Rotating a doubled copy puts requester i_ptr at bit 0.
    assign w_dbl = {i_req, i_req} >> i_ptr;
    assign w_rot = w_dbl[N_REQ-1:0];

    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!o_any && w_rot[k]) begin
                o_any = 1'b1;
                o_idx = PTR_W'((int'(i_ptr) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin sharing of one SPI master between N_REQ byte requesters, one byte exchange per grant.
// Optional WAIT_RX timeout enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int SPI_SIZE       = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*SPI_SIZE-1:0]   req_code,
    input  logic [N_REQ*BYTE_W-1:0]     req_byte,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [BYTE_W-1:0]           rsp_byte,
    output logic                        rsp_err,
    output logic [BYTE_W-1:0]           o_TX_Byte_M,
    output logic                        o_TX_DV_M,
    output logic [SPI_SIZE-1:0]         o_SPI_Code,
    input  logic                        i_TX_Ready_M,
    input  logic                        i_RX_DV_M,
    input  logic [BYTE_W-1:0]           i_RX_Byte_M,
    output logic                        busy,
    output logic [STATE_W-1:0]          o_dbg_state
);

    // Handshake: a requester holds req_valid/code/byte stable until its one-cycle req_ready
    // pulse; the operands are captured the cycle the arbiter picks it, and it may drop
    // req_valid after req_ready. rsp_valid is a one-cycle pulse with no back-pressure.

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [STATE_W-1:0]  r_state;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    r_win;
    logic [PTR_W-1:0]    w_idx;
    logic                w_any;
    logic [SPI_SIZE-1:0] r_code;
    logic [SPI_SIZE-1:0] w_sel_code;
    logic [BYTE_W-1:0]   r_tx_byte;
    logic [BYTE_W-1:0]   w_sel_byte;
    logic [BYTE_W-1:0]   r_rsp_byte;
    logic [N_REQ-1:0]    w_win_oh;
    logic                w_timeout;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_comb begin
        w_sel_code = '0;
        w_sel_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_idx == PTR_W'(i)) begin
                w_sel_code = req_code[i*SPI_SIZE +: SPI_SIZE];
                w_sel_byte = req_byte[i*BYTE_W +: BYTE_W];
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] r_to_cnt;
    logic             r_rsp_err;

    assign w_timeout = (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rsp_err   = r_rsp_err;

    // Held at zero through LAUNCH so the count begins on the first WAIT_RX cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt  <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (r_state == ST_LAUNCH) begin
                r_to_cnt <= '0;
            end else if (r_state == ST_WAIT_RX) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (r_state == ST_WAIT_RX) begin
                if (i_RX_DV_M) begin
                    r_rsp_err <= 1'b0;
                end else if (w_timeout) begin
                    r_rsp_err <= 1'b1;
                end
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_win      <= '0;
            r_code     <= '0;
            r_tx_byte  <= '0;
            r_rsp_byte <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_win     <= w_idx;
                        r_code    <= w_sel_code;
                        r_tx_byte <= w_sel_byte;
                        r_state   <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    r_state <= ST_LAUNCH;
                end
                ST_LAUNCH: begin
                    if (i_TX_Ready_M) begin
                        r_state <= ST_WAIT_RX;
                    end
                end
                ST_WAIT_RX: begin
                    if (i_RX_DV_M) begin
                        r_rsp_byte <= i_RX_Byte_M;
                        r_state    <= ST_RESP;
                    end else if (w_timeout) begin
                        r_rsp_byte <= TIMEOUT_BYTE;
                        r_state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_ptr   <= (r_win == PTR_W'(N_REQ - 1)) ? '0 : r_win + 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Code and TX byte stay registered through IDLE so slave select never glitches.
    assign w_win_oh    = {{(N_REQ-1){1'b0}}, 1'b1} << r_win;
    assign req_ready   = (r_state == ST_GRANT) ? w_win_oh : '0;
    assign rsp_valid   = (r_state == ST_RESP)  ? w_win_oh : '0;
    assign o_TX_DV_M   = (r_state == ST_LAUNCH) && i_TX_Ready_M;
    assign o_TX_Byte_M = r_tx_byte;
    assign o_SPI_Code  = r_code;
    assign rsp_byte    = r_rsp_byte;
    assign busy        = (r_state != ST_IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench for spi_txn_arbiter: vector table plus hand-written corner sequences.
// Covers the SPI_ARB_TIMEOUT_EN build as well when that macro is defined.
module tb_spi_txn_arbiter;
  import spi_arb_pkg::*;

  localparam int N_REQ    = 2;
  localparam int SPI_SIZE = 2;
  localparam int TO_CYC   = 16;
  localparam int SB_W     = 10;  // {err, byte[7:0], winner}

  logic                      clk = 1'b0;
  logic                      rst;
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ*SPI_SIZE-1:0] req_code;
  logic [N_REQ*8-1:0]        req_byte;
  logic [N_REQ-1:0]          req_ready;
  logic [N_REQ-1:0]          rsp_valid;
  logic [7:0]                rsp_byte;
  logic                      rsp_err;
  logic [7:0]                o_TX_Byte_M;
  logic                      o_TX_DV_M;
  logic [SPI_SIZE-1:0]       o_SPI_Code;
  logic                      i_TX_Ready_M;
  logic                      i_RX_DV_M;
  logic [7:0]                i_RX_Byte_M;
  logic                      busy;
  logic [STATE_W-1:0]        o_dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  spi_txn_arbiter #(
    .N_REQ          (N_REQ),
    .SPI_SIZE       (SPI_SIZE),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_code     (req_code),
    .req_byte     (req_byte),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_byte     (rsp_byte),
    .rsp_err      (rsp_err),
    .o_TX_Byte_M  (o_TX_Byte_M),
    .o_TX_DV_M    (o_TX_DV_M),
    .o_SPI_Code   (o_SPI_Code),
    .i_TX_Ready_M (i_TX_Ready_M),
    .i_RX_DV_M    (i_RX_DV_M),
    .i_RX_Byte_M  (i_RX_Byte_M),
    .busy         (busy),
    .o_dbg_state  (o_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int n_rsp = 0;
  logic [SB_W-1:0] exp_q[$];
  logic [SB_W-1:0] mon_e;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid != '0) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(2'b01 << mon_e[0]));
        check("rsp_byte", 32'(rsp_byte), 32'(mon_e[8:1]));
        check("rsp_err", 32'(rsp_err), 32'(mon_e[9]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input int win, input logic [1:0] code, input string nm);
    int k;
    k = 0;
    while (req_ready == '0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_ready"}, 32'(req_ready), 32'(2'b01 << win));
    check({nm, "_code"}, 32'(o_SPI_Code), 32'(code));
  endtask

  task automatic launch(input int busy_cyc, input logic [7:0] tx, input logic [1:0] code,
                        input string nm);
    @(negedge clk);
    for (int i = 0; i < busy_cyc; i++) begin
      check({nm, "_no_dv_busy"}, 32'(o_TX_DV_M), 32'd0);
      @(negedge clk);
    end
    i_TX_Ready_M = 1'b1;
    #1;
    check({nm, "_tx_dv"}, 32'(o_TX_DV_M), 32'd1);
    check({nm, "_tx_byte"}, 32'(o_TX_Byte_M), 32'(tx));
    check({nm, "_tx_code"}, 32'(o_SPI_Code), 32'(code));
    @(negedge clk);
    #1;
    check({nm, "_single_dv"}, 32'(o_TX_DV_M), 32'd0);
    i_TX_Ready_M = 1'b0;
  endtask

  task automatic deliver(input int lat, input logic [7:0] miso);
    repeat (lat) @(negedge clk);
    i_RX_DV_M   = 1'b1;
    i_RX_Byte_M = miso;
    @(negedge clk);
    i_RX_DV_M   = 1'b0;
    i_RX_Byte_M = 8'($urandom_range(0, 255));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  valid;
    logic [3:0]  code;    // {code1, code0}
    logic [15:0] bytes;   // {byte1, byte0}
    logic [7:0]  miso;
    int          busy_cyc;
    logic        drop;
    int          exp_win;
    logic [1:0]  exp_code;
    logic [7:0]  exp_tx;
  } vec_t;

  vec_t vecs[8];

  task automatic do_vector(input vec_t v, input int n);
    string nm;
    nm = $sformatf("vec%0d", n);
    req_valid = v.valid;
    req_code  = v.code;
    req_byte  = v.bytes;
    wait_ready(v.exp_win, v.exp_code, nm);
    if (v.drop) req_valid = '0;
    launch(v.busy_cyc, v.exp_tx, v.exp_code, nm);
    exp_q.push_back({1'b0, v.miso, 1'(v.exp_win)});
    deliver($urandom_range(0, 3), v.miso);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int seen;
    rst = 1'b1;
    req_valid = '0;
    req_code = '0;
    req_byte = '0;
    i_TX_Ready_M = 1'b0;
    i_RX_DV_M = 1'b0;
    i_RX_Byte_M = '0;

    // Pointer starts at 0; rows continue from the pointer left by the previous row.
    vecs[0] = '{2'b01, {2'b00, 2'b00}, {8'h00, 8'hA5}, 8'h3C, 0,  1'b1, 0, 2'b00, 8'hA5};
    vecs[1] = '{2'b11, {2'b01, 2'b00}, {8'h22, 8'h11}, 8'h55, 0,  1'b0, 1, 2'b01, 8'h22};
    vecs[2] = '{2'b11, {2'b01, 2'b00}, {8'h22, 8'h11}, 8'h66, 0,  1'b0, 0, 2'b00, 8'h11};
    vecs[3] = '{2'b11, {2'b01, 2'b00}, {8'h22, 8'h11}, 8'h77, 0,  1'b0, 1, 2'b01, 8'h22};
    vecs[4] = '{2'b11, {2'b01, 2'b00}, {8'h22, 8'h11}, 8'h88, 0,  1'b1, 0, 2'b00, 8'h11};
    vecs[5] = '{2'b01, {2'b11, 2'b10}, {8'hEE, 8'h5A}, 8'h99, 20, 1'b1, 0, 2'b10, 8'h5A};
    vecs[6] = '{2'b10, {2'b11, 2'b00}, {8'hC3, 8'h00}, 8'hE1, 0,  1'b1, 1, 2'b11, 8'hC3};
    vecs[7] = '{2'b11, {2'b10, 2'b01}, {8'hF0, 8'h0F}, 8'h4B, 3,  1'b1, 0, 2'b01, 8'h0F};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_byte", 32'(rsp_byte), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_tx_byte", 32'(o_TX_Byte_M), 32'd0);
    check("rst_tx_dv", 32'(o_TX_DV_M), 32'd0);
    check("rst_code", 32'(o_SPI_Code), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) do_vector(vecs[i], i);

    // Spurious RX_DV while idle
    req_valid = '0;
    @(negedge clk);
    seen = n_rsp;
    i_RX_DV_M = 1'b1;
    i_RX_Byte_M = 8'hEE;
    repeat (3) @(negedge clk);
    i_RX_DV_M = 1'b0;
    @(negedge clk);
    check("spur_rsp_count", 32'(n_rsp), 32'(seen));
    check("spur_rsp_byte", 32'(rsp_byte), 32'h4B);
    check("spur_busy", 32'(busy), 32'd0);

    // Reset during WAIT_RX (pointer is 1 here, so only a cleared pointer grants req0 next)
    req_valid = 2'b10;
    req_code = {2'b01, 2'b00};
    req_byte = {8'h77, 8'h00};
    wait_ready(1, 2'b01, "rstmid");
    req_valid = '0;
    launch(0, 8'h77, 2'b01, "rstmid");
    @(negedge clk);
    check("rstmid_in_wait", 32'(o_dbg_state), 32'(ST_WAIT_RX));
    seen = n_rsp;
    rst = 1'b1;
    #1;
    check("rstmid_req_ready", 32'(req_ready), 32'd0);
    check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstmid_rsp_byte", 32'(rsp_byte), 32'd0);
    check("rstmid_tx_byte", 32'(o_TX_Byte_M), 32'd0);
    check("rstmid_tx_dv", 32'(o_TX_DV_M), 32'd0);
    check("rstmid_code", 32'(o_SPI_Code), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    deliver(0, 8'h12);
    @(negedge clk);
    check("rstmid_no_rsp", 32'(n_rsp), 32'(seen));
    req_valid = 2'b11;
    req_code = {2'b01, 2'b10};
    req_byte = {8'hBB, 8'hAA};
    wait_ready(0, 2'b10, "postrst");
    req_valid = '0;
    launch(0, 8'hAA, 2'b10, "postrst");
    exp_q.push_back({1'b0, 8'hC7, 1'b0});
    deliver(1, 8'hC7);

    // Slave never answers
    req_valid = 2'b01;
    req_code = {2'b00, 2'b11};
    req_byte = {8'h00, 8'h3E};
    wait_ready(0, 2'b11, "norx");
    req_valid = '0;
    launch(0, 8'h3E, 2'b11, "norx");
`ifdef SPI_ARB_TIMEOUT_EN
    exp_q.push_back({1'b1, 8'hFF, 1'b0});
    k = 0;
    while (rsp_valid == '0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("timeout_latency", 32'(k), 32'(TO_CYC));
    @(negedge clk);
    seen = n_rsp;
    deliver(0, 8'h5C);
    repeat (2) @(negedge clk);
    check("late_rx_no_rsp", 32'(n_rsp), 32'(seen));
    check("late_rx_byte", 32'(rsp_byte), 32'hFF);
    check("late_rx_err", 32'(rsp_err), 32'd1);
`else
    seen = n_rsp;
    repeat (40) @(negedge clk);
    check("norx_no_rsp", 32'(n_rsp), 32'(seen));
    check("norx_still_wait", 32'(o_dbg_state), 32'(ST_WAIT_RX));
    check("norx_busy", 32'(busy), 32'd1);
    exp_q.push_back({1'b0, 8'h6D, 1'b0});
    deliver(0, 8'h6D);
    k = 0;
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("final_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
